// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and helpers for the memory-stage access unit.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] WB_MEM = 2'b01;

    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off, input logic we);
        case (f3)
            F3_B:    access_ok = 1'b1;
            F3_H:    access_ok = !off[0];
            F3_W:    access_ok = off == 2'b00;
            F3_BU:   access_ok = !we;
            F3_HU:   access_ok = !we && !off[0];
            default: access_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        byte_en = f3[1] ? 4'b1111 : ((f3[0] ? 4'b0011 : 4'b0001) << off);
    endfunction

    // every lane carries the store data so the enabled lanes always see it
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        store_lanes = f3[1] ? d : f3[0] ? {2{d[15:0]}} : {4{d[7:0]}};
    endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a read word and extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{off, 3'b000} +: 8];
    assign h = off[1] ? rdata[31:16] : rdata[15:0];
    assign result = funct3 == F3_B  ? {{24{b[7]}}, b} :
                    funct3 == F3_BU ? {24'd0, b} :
                    funct3 == F3_H  ? {{16{h[15]}}, h} :
                    funct3 == F3_HU ? {16'd0, h} : rdata;
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit running a req/gnt/rvalid data-memory
// handshake, stalling the pipeline until the access completes or times out.
module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_M,
    input  logic        mem_rd_M,
    input  logic        mem_wr_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic        stall_M,
    output logic        fault_M,
    output logic [31:0] Rdata_W,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d, to_q, to_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]    be_q, be_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   load_fmt;
    logic          access, legal, expired;

    assign access  = mem_valid_M && (mem_rd_M || mem_wr_M);
    assign legal   = access_ok(funct3_M, addr_M[1:0], mem_wr_M);
    assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);

    load_align u_align (
        .rdata  (dmem_rdata),
        .off    (addr_q[1:0]),
        .funct3 (f3_q),
        .result (load_fmt)
    );

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        to_d    = to_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        case (st_q)
            ST_IDLE: if (access && legal) begin
                st_d    = ST_REQ;
                cnt_d   = '0;
                req_d   = 1'b1;
                we_d    = mem_wr_M;
                addr_d  = addr_M;
                f3_d    = funct3_M;
                be_d    = byte_en(funct3_M, addr_M[1:0]);
                wdata_d = store_lanes(funct3_M, wdata_M);
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // a completing store beats expiry; a load granted on the last cycle still times out
                if (dmem_gnt && we_q) begin
                    st_d  = ST_DONE;
                    req_d = 1'b0;
                end else if (expired) begin
                    st_d    = ST_DONE;
                    req_d   = 1'b0;
                    to_d    = 1'b1;
                    rdata_d = we_q ? rdata_q : '0;
                end else if (dmem_gnt) begin
                    st_d  = ST_WAIT;
                    req_d = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_rvalid) begin
                    st_d    = ST_DONE;
                    rdata_d = load_fmt;
                end else if (expired) begin
                    st_d    = ST_DONE;
                    to_d    = 1'b1;
                    rdata_d = '0;
                end
            end
            default: begin
                st_d = ST_IDLE;
                to_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            to_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
        end
    end

    assign stall_M    = st_q == ST_REQ || st_q == ST_WAIT || (st_q == ST_IDLE && access && legal);
    assign fault_M    = (st_q == ST_IDLE && access && !legal) || (st_q == ST_DONE && to_q);
    assign Rdata_W    = rdata_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a
// byte-addressed reference memory and a word-wide bus responder.
module tb_mem_access;
    import mem_pkg::*;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid_M = 1'b0, mem_rd_M = 1'b0, mem_wr_M = 1'b0;
    logic [2:0]  funct3_M = '0;
    logic [31:0] addr_M = '0, wdata_M = '0;
    logic        stall_M, fault_M, dmem_req, dmem_we;
    logic [31:0] Rdata_W, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    logic [7:0]  ref_mem [0:1023];
    logic [31:0] bus_mem [0:255];
    logic [31:0] last_rd = '0;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid_M(mem_valid_M), .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M),
        .funct3_M(funct3_M), .addr_M(addr_M), .wdata_M(wdata_M),
        .stall_M(stall_M), .fault_M(fault_M), .Rdata_W(Rdata_W),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // gd: REQ cycles before gnt; rd: WAIT cycle carrying rvalid (1 = right after gnt)
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int gd, input int rd, input bit rv_never);
        int sz, stalls, reqc, w, exp_st;
        bit legal, to_exp, granted, done;
        logic [3:0] ebe;
        logic [31:0] ewd, v, exp_rd;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!wr && (f3 == 3'd4 || f3 == 3'd5)))
                && (int'(a[1:0]) % sz == 0);
        ebe = 4'(((1 << sz) - 1) << a[1:0]);
        for (int j = 0; j < 4; j++) ewd[8*j +: 8] = d[8*(j % sz) +: 8];
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[10'(a + 32'(i))];
        if (!f3[2] && sz < 4 && v[8*sz-1]) for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        to_exp = wr ? (gd >= TO) : (rv_never || gd + rd >= TO);
        exp_st = to_exp ? 1 + TO : (wr ? 2 + gd : 2 + gd + rd);
        @(posedge clk); #1;
        mem_valid_M = 1'b1; mem_rd_M = !wr; mem_wr_M = wr;
        funct3_M = f3; addr_M = a; wdata_M = d;
        @(negedge clk);
        chk("idle_fault", 32'(fault_M), 32'(!legal));
        chk("idle_stall", 32'(stall_M), 32'(legal));
        @(posedge clk); #1;
        mem_valid_M = 1'b0;
        if (!legal) begin
            @(negedge clk);
            chk("ill_req", 32'(dmem_req), 32'd0);
            chk("ill_stall", 32'(stall_M), 32'd0);
            chk("ill_rdata", Rdata_W, last_rd);
            return;
        end
        stalls = 1; reqc = 0; w = 0; granted = 0; done = 0;
        for (int c = 0; c < 4 * TO && !done; c++) begin
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            if (!stall_M) done = 1;
            else begin
                stalls++;
                if (dmem_req) begin
                    chk("req_addr", dmem_addr, {a[31:2], 2'b00});
                    chk("req_be", 32'(dmem_be), 32'(ebe));
                    chk("req_we", 32'(dmem_we), 32'(wr));
                    if (wr) chk("req_wdata", dmem_wdata, ewd);
                    if (reqc == gd) begin
                        dmem_gnt = 1'b1;
                        granted = 1;
                        if (wr) for (int j = 0; j < 4; j++)
                            if (dmem_be[j]) bus_mem[a[9:2]][8*j +: 8] = dmem_wdata[8*j +: 8];
                    end
                    reqc++;
                end else if (granted) begin
                    w++;
                    if (!rv_never && w == rd) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata = bus_mem[a[9:2]];
                    end
                end
            end
        end
        if (!done) begin
            chk("done_reached", 32'd0, 32'd1);
            return;
        end
        exp_rd = wr ? last_rd : (to_exp ? 32'd0 : v);
        chk("stall_cycles", 32'(stalls), 32'(exp_st));
        chk("done_fault", 32'(fault_M), 32'(to_exp));
        chk("done_req", 32'(dmem_req), 32'd0);
        chk("rdata", Rdata_W, exp_rd);
        if (!to_exp) chk("req_cycles", 32'(reqc), 32'(gd + 1));
        last_rd = exp_rd;
        if (wr && !to_exp) for (int i = 0; i < sz; i++) ref_mem[10'(a + 32'(i))] = d[8*i +: 8];
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = $urandom;
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = bus_mem[i][8*j +: 8];
        end
        @(negedge clk);
        chk("rst_stall", 32'(stall_M), 32'd0);
        chk("rst_fault", 32'(fault_M), 32'd0);
        chk("rst_rdata", Rdata_W, 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, 1, 0);
        access(1'b1, F3_W, 32'h100, 32'h80FF1234, 0, 1, 0);
        access(1'b0, F3_B, 32'h103, 32'd0, 0, 1, 0);
        chk("lb_literal", Rdata_W, 32'hFFFF_FF80);
        access(1'b0, F3_BU, 32'h103, 32'd0, 0, 1, 0);
        chk("lbu_literal", Rdata_W, 32'h0000_0080);
        access(1'b1, F3_H, 32'h102, 32'h0000ABCD, 3, 1, 0);
        access(1'b0, F3_W, 32'h100, 32'd0, 0, 1, 0);
        chk("sh_literal", Rdata_W, 32'hABCD_1234);
        access(1'b0, F3_W, 32'h101, 32'd0, 0, 1, 0);
        access(1'b0, F3_H, 32'h200, 32'd0, 0, 1, 1);
        access(1'b0, F3_W, 32'h100, 32'd0, 1, 2, 0);
        @(posedge clk); #1;
        mem_valid_M = 1'b1; mem_rd_M = 1'b1; mem_wr_M = 1'b0;
        funct3_M = F3_W; addr_M = 32'h104;
        @(posedge clk); #1;
        mem_valid_M = 1'b0;
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk("pre_rst_stall", 32'(stall_M), 32'd1);
        chk("pre_rst_rdata", Rdata_W, last_rd);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(dmem_req), 32'd0);
        chk("midrst_stall", 32'(stall_M), 32'd0);
        chk("midrst_rdata", Rdata_W, 32'd0);
        last_rd = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(1'b0, F3_W, 32'h0, 32'd0, 0, 1, 0);
        for (int k = 0; k < 120; k++) begin
            logic wr;
            logic [2:0] f3;
            logic [31:0] a;
            int gd;
            bit rvn;
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            gd = $urandom_range(0, 3);
            rvn = $urandom_range(0, 9) == 0;
            if (wr && rvn) gd = TO;
            access(wr, f3, a, $urandom, gd, $urandom_range(1, 3), rvn);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
